tb_dina_seq: RTL and testbench
==============================

// Module: tb_dina_seq
// PURPOSE
//  Command-driven sequencer sitting directly upstream of the TB write-data mapper. Per command it
//  issues coefficient-buffer (CB) port-A reads, drives the mapper's select/l_k_0/sequence-count inputs
//  aligned to CB read latency, and raises temp-buffer (TB) port-A write enable/address aligned to the
//  mapper's 1-cycle registered output. Covers CB copy (POS/NEG/NEW) and non-linear (NL) Jacobian fills.
// PARAMETERS
//  L               4   lanes per TB word (informational; no datapath here)
//  ADDR_DW         10  CB and TB port-A address width
//  SEQ_CNT_DW      10  command length / seq_cnt_out width
//  TB_DINA_SEL_DW  3   mapper select width: [2]=0 CB source / 1 NL source; [1:0]=IDLE/POS/NEG/NEW (00/01/10/11)
//  CB_RD_LAT       1   CB port-A read latency in cycles (>=1)
// PORTS
//  clk            in   1               clock
//  sys_rst_n      in   1               reset, asynchronous, active-low
//  cmd_valid      in   1               command offered
//  cmd_ready      out  1               command accepted when cmd_valid & cmd_ready
//  cmd_sel        in   TB_DINA_SEL_DW  mapper select for this command
//  cmd_l_k_0      in   1               NEW-mode lane placement bit, forwarded to mapper
//  cmd_len        in   SEQ_CNT_DW      number of TB words to write (0 = no-op)
//  cmd_cb_base    in   ADDR_DW         first CB read address (ignored in NL mode)
//  cmd_tb_base    in   ADDR_DW         first TB write address
//  cb_ena         out  1               CB port-A read enable
//  cb_addra       out  ADDR_DW         CB port-A read address
//  TB_dina_sel    out  TB_DINA_SEL_DW  to mapper
//  l_k_0          out  1               to mapper
//  seq_cnt_out    out  SEQ_CNT_DW      to mapper; 1-based index of the word entering the mapper
//  tb_ena         out  1               TB port-A enable
//  tb_wea         out  1               TB port-A write enable
//  tb_addra       out  ADDR_DW         TB port-A write address
//  busy           out  1               command in flight
//  done           out  1               1-cycle pulse with the last TB write (or no-op completion)
// BEHAVIOUR
//  - Reset (async assert, sync deassert): all outputs 0 except cmd_ready=1; FSM=IDLE; pipeline flushed.
//  - FSM IDLE -> ISSUE on accept (len>0); IDLE -> NOP on accept (len=0); NOP -> IDLE (done=1, no enables).
//    ISSUE -> DRAIN after word len issued; DRAIN -> IDLE with last write. cmd_ready = (state==IDLE).
//  - cmd_valid while busy: ignored, no side effect. Command fields registered at accept.
//  - Define P = CB_RD_LAT for CB modes (sel[2]=0), P = 0 for NL. Word k (0..len-1) issued at cycle t0+k,
//    t0 = cycle after accept:
//      CB mode: cb_ena=1, cb_addra=cb_base+k at t0+k.
//      seq_cnt_out=k+1 at t0+k+P (mapper input cycle); 0 when no word at mapper input.
//      tb_ena=tb_wea=1, tb_addra=tb_base+k at t0+k+P+1. done=1 with k=len-1 write.
//  - One word per cycle, no bubbles; total busy = len+P+1 cycles.
//  - TB_dina_sel/l_k_0 held at command value from t0 until the cycle after done; 0 otherwise
//    (CB/DIR_IDLE -> mapper outputs 0, never written since tb_wea=0).
//  - Addresses wrap modulo 2^ADDR_DW; no range error.
//  - NL mode: cb_ena stays 0 throughout.
// STRUCTURE
//  - Shared package/header: TB_DINA_SEL encodings (TBa_CBa, TBa_NL, DIR_IDLE/POS/NEG/NEW), FSM state codes.
//  - One sub-module: tb_seq_delay_line (parameterised-depth valid+index+addr shift register, async
//    active-low reset) used for the P and P+1 alignment taps.
// TESTING
//  - POS copy, len=4, cb_base=0x10, tb_base=0x20, CB_RD_LAT=1: cb_addra 0x10..0x13 at t0..t0+3;
//    seq_cnt 1..4 at t0+1..t0+4; tb_addra 0x20..0x23 at t0+2..t0+5; done with 0x23; busy 6 cycles.
//  - NL, len=5, tb_base=0x08: cb_ena never 1; seq_cnt 1..5 at t0..t0+4; tb_wea at t0+1..t0+5,
//    tb_addra 0x08..0x0C; TB_dina_sel=3'b100 held until cycle after done.
//  - len=0 (NEG): no cb_ena/tb_wea, done pulses exactly once, cmd_ready back high next cycle.
//  - Wrap: cb_base=tb_base=0x3FE, len=4, ADDR_DW=10: addresses 0x3FE,0x3FF,0x000,0x001.
//  - Second cmd_valid asserted during busy: ignored; accepted only after IDLE; back-to-back commands
//    run with no overlap of tb_wea.
//  - sys_rst_n pulled low mid-ISSUE: all enables drop asynchronously; after release cmd_ready=1, no
//    stale writes emerge from the delay line.

Source files
------------

// File: rtl/tb_dina_seq_pkg.sv
// +--------------------------------------------------------------------------+
// | tb_dina_seq_pkg : shared encodings for the TB write-data sequencer        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package tb_dina_seq_pkg;

  // Mapper select: bit [2] picks the source, bits [1:0] the CB copy direction.
  localparam logic       TBA_CBA  = 1'b0;
  localparam logic       TBA_NL   = 1'b1;
  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_NEW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_NOP   = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/tb_seq_delay_line.sv
// +--------------------------------------------------------------------------+
// | tb_seq_delay_line : valid/index/address shift register, all stages tapped |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_seq_delay_line #(
  parameter int DEPTH   = 2,
  parameter int IDX_DW  = 10,
  parameter int ADDR_DW = 10
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [IDX_DW-1:0]                in_idx,
  input  logic [ADDR_DW-1:0]               in_addr,
  output logic [DEPTH:0]                   tap_valid,
  output logic [DEPTH:0][IDX_DW-1:0]       tap_idx,
  output logic [DEPTH:0][ADDR_DW-1:0]      tap_addr
);

  logic [DEPTH:1]                r_valid;
  logic [DEPTH:1][IDX_DW-1:0]    r_idx;
  logic [DEPTH:1][ADDR_DW-1:0]   r_addr;

  // Tap 0 is the live input; tap i is the input delayed by i cycles.
  assign tap_valid = {r_valid, in_valid};
  assign tap_idx   = {r_idx, in_idx};
  assign tap_addr  = {r_addr, in_addr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_idx   <= '0;
      r_addr  <= '0;
    end else begin
      for (int i = 1; i <= DEPTH; i++) begin
        r_valid[i] <= flush ? 1'b0 : tap_valid[i-1];
        r_idx[i]   <= tap_idx[i-1];
        r_addr[i]  <= tap_addr[i-1];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tb_dina_seq.sv
// +--------------------------------------------------------------------------+
// | tb_dina_seq : command sequencer feeding CB reads, mapper and TB writes    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_dina_seq
  import tb_dina_seq_pkg::*;
#(
  parameter int L              = 4,
  parameter int ADDR_DW        = 10,
  parameter int SEQ_CNT_DW     = 10,
  parameter int TB_DINA_SEL_DW = 3,
  parameter int CB_RD_LAT      = 1
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [TB_DINA_SEL_DW-1:0] cmd_sel,
  input  logic                      cmd_l_k_0,
  input  logic [SEQ_CNT_DW-1:0]     cmd_len,
  input  logic [ADDR_DW-1:0]        cmd_cb_base,
  input  logic [ADDR_DW-1:0]        cmd_tb_base,
  output logic                      cb_ena,
  output logic [ADDR_DW-1:0]        cb_addra,
  output logic [TB_DINA_SEL_DW-1:0] TB_dina_sel,
  output logic                      l_k_0,
  output logic [SEQ_CNT_DW-1:0]     seq_cnt_out,
  output logic                      tb_ena,
  output logic                      tb_wea,
  output logic [ADDR_DW-1:0]        tb_addra,
  output logic                      busy,
  output logic                      done
);

  localparam int                    c_dl_depth = CB_RD_LAT + 1;
  localparam logic [SEQ_CNT_DW-1:0] c_seq_one  = SEQ_CNT_DW'(1);

  generate
    if (L < 1 || CB_RD_LAT < 1) begin : g_param_invalid
    end
  endgenerate

  seq_state_t                r_state, w_next;
  logic [TB_DINA_SEL_DW-1:0] r_sel;
  logic                      r_l_k_0;
  logic [SEQ_CNT_DW-1:0]     r_len, r_k;
  logic [ADDR_DW-1:0]        r_cb_base, r_tb_base;
  logic                      r_tail;

  logic                                  w_accept, w_nl;
  logic [c_dl_depth:0]                   w_tap_valid;
  logic [c_dl_depth:0][SEQ_CNT_DW-1:0]   w_tap_idx;
  logic [c_dl_depth:0][ADDR_DW-1:0]      w_tap_addr;
  logic                                  w_map_v, w_wr_v, w_last_wr;
  logic [SEQ_CNT_DW-1:0]                 w_map_idx, w_wr_idx;
  logic [ADDR_DW-1:0]                    w_wr_addr;
  logic                                  w_unused_taps;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_nl     = (r_sel[TB_DINA_SEL_DW-1] == TBA_NL);

  // NL words skip the CB read latency, so they are picked off one tap pair earlier.
  assign w_map_v   = w_nl ? w_tap_valid[0] : w_tap_valid[CB_RD_LAT];
  assign w_map_idx = w_nl ? w_tap_idx[0]   : w_tap_idx[CB_RD_LAT];
  assign w_wr_v    = (r_state != ST_IDLE) && (w_nl ? w_tap_valid[1] : w_tap_valid[c_dl_depth]);
  assign w_wr_idx  = w_nl ? w_tap_idx[1]   : w_tap_idx[c_dl_depth];
  assign w_wr_addr = w_nl ? w_tap_addr[1]  : w_tap_addr[c_dl_depth];
  assign w_last_wr = w_wr_v && (w_wr_idx == r_len);

  assign w_unused_taps = ^{w_tap_valid, w_tap_idx, w_tap_addr};

  tb_seq_delay_line #(
    .DEPTH   (c_dl_depth),
    .IDX_DW  (SEQ_CNT_DW),
    .ADDR_DW (ADDR_DW)
  ) u_delay (
    .clk       (clk),
    .rst_n     (sys_rst_n),
    .flush     (w_accept),
    .in_valid  (r_state == ST_ISSUE),
    .in_idx    (r_k + c_seq_one),
    .in_addr   (r_tb_base + ADDR_DW'(r_k)),
    .tap_valid (w_tap_valid),
    .tap_idx   (w_tap_idx),
    .tap_addr  (w_tap_addr)
  );

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= ST_IDLE;
    else            r_state <= w_next;
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sel     <= '0;
      r_l_k_0   <= 1'b0;
      r_len     <= '0;
      r_k       <= '0;
      r_cb_base <= '0;
      r_tb_base <= '0;
      r_tail    <= 1'b0;
    end else begin
      r_tail <= done;
      if (w_accept) begin
        r_sel     <= cmd_sel;
        r_l_k_0   <= cmd_l_k_0;
        r_len     <= cmd_len;
        r_cb_base <= cmd_cb_base;
        r_tb_base <= cmd_tb_base;
        r_k       <= '0;
      end else if (r_state == ST_ISSUE) begin
        r_k <= r_k + c_seq_one;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    cmd_ready   = 1'b0;
    busy        = 1'b0;
    cb_ena      = 1'b0;
    cb_addra    = '0;
    seq_cnt_out = '0;
    tb_ena      = 1'b0;
    tb_wea      = 1'b0;
    tb_addra    = '0;
    done        = 1'b0;
    TB_dina_sel = '0;
    l_k_0       = 1'b0;

    case (r_state)
      ST_IDLE:  if (w_accept) w_next = (cmd_len == '0) ? ST_NOP : ST_ISSUE;
      ST_ISSUE: if (r_k == r_len - c_seq_one) w_next = ST_DRAIN;
      ST_DRAIN: if (w_last_wr) w_next = ST_IDLE;
      ST_NOP:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase

    cmd_ready = (r_state == ST_IDLE);
    busy      = !cmd_ready;
    if (r_state == ST_ISSUE && !w_nl) begin
      cb_ena   = 1'b1;
      cb_addra = r_cb_base + ADDR_DW'(r_k);
    end
    if (w_map_v) seq_cnt_out = w_map_idx;
    if (w_wr_v) begin
      tb_ena   = 1'b1;
      tb_wea   = 1'b1;
      tb_addra = w_wr_addr;
    end
    done = (r_state == ST_NOP) || ((r_state == ST_DRAIN) && w_last_wr);
    // Select stays up one cycle past done so the mapper's registered last word sees it.
    if (busy || r_tail) begin
      TB_dina_sel = r_sel;
      l_k_0       = r_l_k_0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tb_dina_seq.sv
// Randomized bench for tb_dina_seq: per-cycle outputs compared against a
// timing model computed directly from command fields.
`default_nettype none

module tb_tb_dina_seq;

  localparam int ADDR_DW = 10;
  localparam int SEQ_DW  = 10;
  localparam int SEL_DW  = 3;
  localparam int LAT     = 1;

  logic              clk = 1'b0;
  logic              sys_rst_n;
  logic              cmd_valid, cmd_ready;
  logic [SEL_DW-1:0] cmd_sel;
  logic              cmd_l_k_0;
  logic [SEQ_DW-1:0] cmd_len;
  logic [ADDR_DW-1:0] cmd_cb_base, cmd_tb_base;
  logic              cb_ena;
  logic [ADDR_DW-1:0] cb_addra;
  logic [SEL_DW-1:0] TB_dina_sel;
  logic              l_k_0;
  logic [SEQ_DW-1:0] seq_cnt_out;
  logic              tb_ena, tb_wea;
  logic [ADDR_DW-1:0] tb_addra;
  logic              busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tb_dina_seq #(
    .L(4), .ADDR_DW(ADDR_DW), .SEQ_CNT_DW(SEQ_DW), .TB_DINA_SEL_DW(SEL_DW), .CB_RD_LAT(LAT)
  ) dut (
    .clk(clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel), .cmd_l_k_0(cmd_l_k_0),
    .cmd_len(cmd_len), .cmd_cb_base(cmd_cb_base), .cmd_tb_base(cmd_tb_base),
    .cb_ena(cb_ena), .cb_addra(cb_addra), .TB_dina_sel(TB_dina_sel), .l_k_0(l_k_0),
    .seq_cnt_out(seq_cnt_out), .tb_ena(tb_ena), .tb_wea(tb_wea), .tb_addra(tb_addra),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " cb"},   {cb_ena, cb_addra}, 32'h0);
    check({tag, " seq"},  32'(seq_cnt_out), 32'h0);
    check({tag, " tb"},   {tb_ena, tb_wea, tb_addra}, 32'h0);
    check({tag, " ctl"},  {done, busy, cmd_ready}, 32'h1);
    check({tag, " sel"},  {TB_dina_sel, l_k_0}, 32'h0);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge of the
  // cycle after done, leaving cmd_valid low.
  task automatic run_cmd(input logic [2:0] sel, input logic lk0, input int len,
                         input int cbb, input int tbb, input bit junk);
    bit nl;
    int p, d;
    logic [31:0] e_cb, e_seq, e_tb, e_ctl;
    nl = sel[2];
    p  = nl ? 0 : LAT;
    d  = (len == 0) ? 0 : len + p;
    check("ready_before_cmd", 32'(cmd_ready), 32'h1);
    cmd_valid   = 1'b1;
    cmd_sel     = sel;
    cmd_l_k_0   = lk0;
    cmd_len     = len[SEQ_DW-1:0];
    cmd_cb_base = cbb[ADDR_DW-1:0];
    cmd_tb_base = tbb[ADDR_DW-1:0];
    @(posedge clk);
    for (int c = 0; c <= d + 1; c++) begin
      @(negedge clk);
      e_cb  = (!nl && c < len) ? (32'h400 | ((cbb + c) & 32'h3FF)) : 32'h0;
      e_seq = (len > 0 && c >= p && c - p < len) ? 32'(c - p + 1) : 32'h0;
      e_tb  = (len > 0 && c >= p + 1 && c - p - 1 < len) ?
              (32'hC00 | ((tbb + c - p - 1) & 32'h3FF)) : 32'h0;
      e_ctl = (c == d) ? 32'h6 : ((c < d) ? 32'h2 : 32'h1);
      check($sformatf("cb c=%0d", c),  {cb_ena, cb_addra}, e_cb);
      check($sformatf("seq c=%0d", c), 32'(seq_cnt_out), e_seq);
      check($sformatf("tb c=%0d", c),  {tb_ena, tb_wea, tb_addra}, e_tb);
      check($sformatf("ctl c=%0d", c), {done, busy, cmd_ready}, e_ctl);
      check($sformatf("sel c=%0d", c), {TB_dina_sel, l_k_0}, {sel, lk0});
      if (junk && c < d) begin
        cmd_valid   = 1'b1;
        cmd_sel     = 3'($urandom);
        cmd_l_k_0   = 1'($urandom);
        cmd_len     = 10'($urandom_range(0, 15));
        cmd_cb_base = 10'($urandom);
        cmd_tb_base = 10'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  initial begin
    sys_rst_n   = 1'b0;
    cmd_valid   = 1'b0;
    cmd_sel     = '0;
    cmd_l_k_0   = 1'b0;
    cmd_len     = '0;
    cmd_cb_base = '0;
    cmd_tb_base = '0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    sys_rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    run_cmd(3'b001, 1'b0, 4, 'h10, 'h20, 1'b0);   // POS copy
    run_cmd(3'b100, 1'b0, 5, 'h00, 'h08, 1'b0);   // NL fill, back-to-back
    run_cmd(3'b010, 1'b0, 0, 'h05, 'h05, 1'b1);   // NEG no-op
    @(negedge clk);
    check_idle("after_nop");
    run_cmd(3'b011, 1'b1, 4, 'h3FE, 'h3FE, 1'b1); // NEW with wrap, busy-time noise

    // Reset pulled mid-command: everything drops at once, nothing stale follows.
    cmd_valid = 1'b1; cmd_sel = 3'b001; cmd_l_k_0 = 1'b0;
    cmd_len = 10'd8; cmd_cb_base = 10'h100; cmd_tb_base = 10'h200;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_write_before_rst", {tb_ena, tb_wea, tb_addra}, 32'hE01);
    #2 sys_rst_n = 1'b0;
    #1 check_idle("async_rst");
    @(negedge clk);
    sys_rst_n = 1'b1;
    repeat (LAT + 4) begin
      @(negedge clk);
      check_idle("no_stale");
    end

    for (int i = 0; i < 40; i++) begin
      int len;
      len = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 12));
      run_cmd(3'($urandom), 1'($urandom), len, int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_idle("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
